pgm_mem_arbiter: RTL and testbench

- Shares one 16-bit external memory port among three requesters: the HPS ROM download stream (ioctl), the 68000 program-fetch port (port A) and the Z80 sound port (port B).
- Sits between hps_io, the PGM core and the SDRAM controller in emu.
- During download, only ioctl writes are serviced and CPU ports are held off. Otherwise A and B are served round-robin.
- A per-access watchdog flags a memory port that never acknowledges.

---
 rtl/pgm_mem_pkg.sv | 27 ++
 rtl/pgm_mem_arbiter_if.sv | 30 +++
 rtl/pgm_dl_buffer.sv | 46 ++++
 rtl/pgm_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_pgm_mem_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pgm_mem_pkg.sv
// pgm_mem_pkg: shared types and constants for the PGM memory arbiter.
// Holds the arbiter state encoding and the download region prefixes.
package pgm_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DL_WR,
        ST_RD_A,
        ST_RD_B
    } arb_state_e;

    // ioctl_index[1:0] becomes the top two bits of the word address
    typedef enum logic [1:0] {
        RGN_PROG  = 2'd0,
        RGN_AUDIO = 2'd1,
        RGN_GFX   = 2'd2,
        RGN_SPR   = 2'd3
    } region_e;

    localparam int          TIMEOUT_DEF = 255;
    localparam logic [15:0] RD_ERR_DATA = 16'hFFFF;

    function automatic region_e region_of(input logic [1:0] idx);
        return region_e'(idx);
    endfunction

endpackage

// File: rtl/pgm_mem_arbiter_if.sv
// pgm_mem_arbiter_if: 16-bit external memory port handshake.
// Level request held until a one-cycle ack from the memory side.
interface pgm_mem_arbiter_if #(
    parameter int ADDR_W = 24
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic              mem_ack;
    logic [15:0]       mem_dout;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_din,
        input  mem_ack,
        input  mem_dout
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_din,
        output mem_ack,
        output mem_dout
    );
endinterface

// File: rtl/pgm_dl_buffer.sv
// pgm_dl_buffer: one-entry holding register for HPS download words.
// While full, the HPS is told to wait and further strobes are dropped.
module pgm_dl_buffer #(
    parameter int AW = 22
) (
    input  logic          CLK_50M,
    input  logic          RESET,
    input  logic          i_wr,
    input  logic [AW-1:0] i_addr,
    input  logic [15:0]   i_data,
    input  logic [1:0]    i_region,
    input  logic          i_clr,
    output logic          o_full,
    output logic          o_wait,
    output logic [AW-1:0] o_addr,
    output logic [15:0]   o_data,
    output logic [1:0]    o_region
);
    logic          r_full;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_data;
    logic [1:0]    r_region;

    // capture a strobe into an empty slot; drain once the write retires
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_full   <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_region <= '0;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end else if (i_wr && !r_full) begin
            r_full   <= 1'b1;
            r_addr   <= i_addr;
            r_data   <= i_data;
            r_region <= i_region;
        end
    end

    assign o_full   = r_full;
    assign o_wait   = r_full;
    assign o_addr   = r_addr;
    assign o_data   = r_data;
    assign o_region = r_region;
endmodule

// File: rtl/pgm_mem_arbiter.sv
// pgm_mem_arbiter: shares one 16-bit memory port between the HPS
// download stream and the 68000 (A) / Z80 (B) read ports.
module pgm_mem_arbiter
    import pgm_mem_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              CLK_50M,
    input  logic              RESET,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [26:0]       ioctl_addr,
    input  logic [15:0]       ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ack,
    output logic [15:0]       a_data,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_ack,
    output logic [15:0]       b_data,
    pgm_mem_arbiter_if.master mem,
    output logic              timeout_err
);
    localparam int DL_AW = ADDR_W - 2;
    localparam int WD_W  = ($clog2(TIMEOUT + 1) > 8) ?
                           $clog2(TIMEOUT + 1) : 8;
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT);

    logic             w_buf_full;
    logic             w_buf_clr;
    logic [DL_AW-1:0] w_buf_addr;
    logic [15:0]      w_buf_data;
    logic [1:0]       w_buf_rgn;
    logic [ADDR_W-1:0] w_dl_addr;
    logic             w_unused_ioctl;

    arb_state_e        r_state;
    logic              r_ptr;
    logic [WD_W-1:0]   r_wd;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_din;
    logic              r_a_ack;
    logic [15:0]       r_a_data;
    logic              r_b_ack;
    logic [15:0]       r_b_data;
    logic              r_timeout_err;

    logic [WD_W-1:0] w_wd_nxt;
    logic            w_expire;
    logic            w_done;
    logic            w_a_pend;
    logic            w_b_pend;
    logic            w_pick_b;

    assign w_unused_ioctl = ^{ioctl_index[7:2],
                              ioctl_addr[26:ADDR_W-1],
                              ioctl_addr[0]};

    pgm_dl_buffer #(
        .AW (DL_AW)
    ) u_dl_buffer (
        .CLK_50M  (CLK_50M),
        .RESET    (RESET),
        .i_wr     (ioctl_wr),
        .i_addr   (ioctl_addr[ADDR_W-2:1]),
        .i_data   (ioctl_dout),
        .i_region (ioctl_index[1:0]),
        .i_clr    (w_buf_clr),
        .o_full   (w_buf_full),
        .o_wait   (ioctl_wait),
        .o_addr   (w_buf_addr),
        .o_data   (w_buf_data),
        .o_region (w_buf_rgn)
    );

    assign w_dl_addr = {region_of(w_buf_rgn), w_buf_addr};

    // the port acked last cycle still shows req; do not re-grant it
    assign w_a_pend = a_req && !r_a_ack;
    assign w_b_pend = b_req && !r_b_ack;
    assign w_pick_b = w_b_pend && (r_ptr || !w_a_pend);

    assign w_wd_nxt  = r_wd + 1'b1;
    assign w_expire  = !mem.mem_ack && (w_wd_nxt == WD_LIM);
    assign w_done    = mem.mem_ack || w_expire;
    assign w_buf_clr = (r_state == ST_DL_WR) && w_done;

    // grant, access tracking, watchdog and requester acks
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_ptr         <= 1'b0;
            r_wd          <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_din     <= '0;
            r_a_ack       <= 1'b0;
            r_a_data      <= '0;
            r_b_ack       <= 1'b0;
            r_b_data      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_wd <= '0;
                    if (w_buf_full) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= w_dl_addr;
                        r_mem_din  <= w_buf_data;
                        r_state    <= ST_DL_WR;
                    end else if (!ioctl_download &&
                                 (w_a_pend || w_b_pend)) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_pick_b ? b_addr : a_addr;
                        r_state    <= w_pick_b ? ST_RD_B : ST_RD_A;
                    end
                end
                ST_DL_WR: begin
                    r_wd <= w_wd_nxt;
                    if (w_done) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= ST_IDLE;
                        if (w_expire) r_timeout_err <= 1'b1;
                    end
                end
                ST_RD_A: begin
                    r_wd <= w_wd_nxt;
                    if (w_done) begin
                        r_mem_req <= 1'b0;
                        r_ptr     <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_a_ack   <= 1'b1;
                        r_a_data  <= w_expire ? RD_ERR_DATA
                                              : mem.mem_dout;
                        if (w_expire) r_timeout_err <= 1'b1;
                    end
                end
                ST_RD_B: begin
                    r_wd <= w_wd_nxt;
                    if (w_done) begin
                        r_mem_req <= 1'b0;
                        r_ptr     <= 1'b0;
                        r_state   <= ST_IDLE;
                        r_b_ack   <= 1'b1;
                        r_b_data  <= w_expire ? RD_ERR_DATA
                                              : mem.mem_dout;
                        if (w_expire) r_timeout_err <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign mem.mem_req  = r_mem_req;
    assign mem.mem_we   = r_mem_we;
    assign mem.mem_addr = r_mem_addr;
    assign mem.mem_din  = r_mem_din;
    assign a_ack        = r_a_ack;
    assign a_data       = r_a_data;
    assign b_ack        = r_b_ack;
    assign b_data       = r_b_data;
    assign timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_pgm_mem_arbiter.sv
// tb_pgm_mem_arbiter: table-driven reads plus download, priority,
// timeout, reset and round-robin sequences against a memory model.
module tb_pgm_mem_arbiter;
    localparam int AW = 24;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [26:0] ioctl_addr = '0;
    logic [15:0] ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wait;
    logic        a_req = 1'b0;
    logic [23:0] a_addr = '0;
    logic        a_ack;
    logic [15:0] a_data;
    logic        b_req = 1'b0;
    logic [23:0] b_addr = '0;
    logic        b_ack;
    logic [15:0] b_data;
    logic        timeout_err;

    always #10 clk = ~clk;

    pgm_mem_arbiter_if #(.ADDR_W(AW)) mif ();

    pgm_mem_arbiter #(
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .CLK_50M        (clk),
        .RESET          (rst),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .a_req          (a_req),
        .a_addr         (a_addr),
        .a_ack          (a_ack),
        .a_data         (a_data),
        .b_req          (b_req),
        .b_addr         (b_addr),
        .b_ack          (b_ack),
        .b_data         (b_data),
        .mem            (mif),
        .timeout_err    (timeout_err)
    );

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [15:0] din;
    } acc_t;

    typedef struct packed {
        logic        pb;
        logic [15:0] data;
    } ack_t;

    typedef struct packed {
        logic        pb;
        logic [23:0] addr;
        int          lat;
        logic [15:0] data;
    } vec_t;

    acc_t acc_q[$];
    ack_t ack_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   resp_lat = 2;
    bit   resp_en = 1'b1;
    int   lat_cnt = 0;
    int   last_len = 0;

    function automatic logic [15:0] rd_model(input logic [23:0] ad);
        if (ad == 24'h001234) return 16'hCAFE;
        return ad[15:0] ^ 16'hA5C3;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // memory model: ack after resp_lat cycles, data from rd_model
    always @(posedge clk) begin
        if (rst || !mif.mem_req || mif.mem_ack) begin
            lat_cnt      <= 0;
            mif.mem_ack  <= 1'b0;
            mif.mem_dout <= 16'h1111;
        end else if (resp_en && lat_cnt >= resp_lat - 1) begin
            lat_cnt      <= 0;
            mif.mem_ack  <= 1'b1;
            mif.mem_dout <= rd_model(mif.mem_addr);
        end else begin
            lat_cnt <= lat_cnt + 1;
        end
    end

    // monitor: pop expected accesses and acks as the DUT produces them
    initial begin
        bit   prev;
        bit   prev_a;
        bit   prev_b;
        int   len;
        acc_t e;
        ack_t k;
        prev = 1'b0;
        prev_a = 1'b0;
        prev_b = 1'b0;
        len = 0;
        forever begin
            @(negedge clk);
            if (mif.mem_req === 1'b1 && !prev) begin
                if (acc_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL mem_extra: got access we=%0b addr=%0h, expected none",
                             mif.mem_we, mif.mem_addr);
                end else begin
                    e = acc_q.pop_front();
                    chk("mem_we", 64'(mif.mem_we), 64'(e.we));
                    chk("mem_addr", 64'(mif.mem_addr), 64'(e.addr));
                    if (e.we) chk("mem_din", 64'(mif.mem_din), 64'(e.din));
                end
            end
            if (a_ack === 1'b1) begin
                if (prev_a) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL a_ack_width: got 2+ cycles, expected 1");
                end else if (ack_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL a_ack_extra: got ack data=%0h, expected none", a_data);
                end else begin
                    k = ack_q.pop_front();
                    chk("a_ack", 64'({1'b0, a_data}), 64'({k.pb, k.data}));
                end
            end
            if (b_ack === 1'b1) begin
                if (prev_b) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL b_ack_width: got 2+ cycles, expected 1");
                end else if (ack_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL b_ack_extra: got ack data=%0h, expected none", b_data);
                end else begin
                    k = ack_q.pop_front();
                    chk("b_ack", 64'({1'b1, b_data}), 64'({k.pb, k.data}));
                end
            end
            if (mif.mem_req === 1'b1) len = prev ? len + 1 : 1;
            else if (prev) last_len = len;
            prev = (mif.mem_req === 1'b1);
            prev_a = (a_ack === 1'b1);
            prev_b = (b_ack === 1'b1);
        end
    end

    task automatic wait_ack(input bit pb);
        int t = 0;
        forever begin
            @(negedge clk);
            if (pb ? b_ack : a_ack) break;
            t++;
            if (t > 100) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_ack_timeout: got no ack in %0d cycles, expected ack",
                         pb ? "b" : "a", t);
                break;
            end
        end
    endtask

    task automatic do_read(input bit pb, input logic [23:0] ad);
        if (pb) begin
            b_addr = ad;
            b_req = 1'b1;
        end else begin
            a_addr = ad;
            a_req = 1'b1;
        end
        wait_ack(pb);
        if (pb) b_req = 1'b0;
        else a_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_mem_ack(input string nm);
        int t = 0;
        while (mif.mem_ack !== 1'b1) begin
            @(negedge clk);
            t++;
            if (t > 100) begin
                n_vec++;
                n_err++;
                $display("FAIL %s: got no mem_ack in %0d cycles, expected mem_ack", nm, t);
                break;
            end
        end
    endtask

    task automatic dl_write(input logic [26:0] ad, input logic [15:0] d,
                            input logic [7:0] idx);
        ioctl_addr = ad;
        ioctl_dout = d;
        ioctl_index = idx;
        ioctl_wr = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t vecs[6];
        int   seen;
        int   t;
        vecs[0] = '{1'b0, 24'h001234, 3, 16'hCAFE};
        vecs[1] = '{1'b1, 24'h00FF00, 1, rd_model(24'h00FF00)};
        vecs[2] = '{1'b0, 24'hFFFFFF, 5, rd_model(24'hFFFFFF)};
        vecs[3] = '{1'b1, 24'h000000, 2, rd_model(24'h000000)};
        vecs[4] = '{1'b0, 24'h800001, 1, rd_model(24'h800001)};
        vecs[5] = '{1'b1, 24'h7FFFFE, 4, rd_model(24'h7FFFFE)};

        repeat (3) @(negedge clk);
        chk("reset_ctl", 64'({mif.mem_req, mif.mem_we, a_ack, b_ack,
                              ioctl_wait, timeout_err}), 64'(0));
        chk("reset_bus", 64'({mif.mem_addr, mif.mem_din}), 64'(0));
        chk("reset_data", 64'({a_data, b_data}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            resp_lat = vecs[i].lat;
            acc_q.push_back('{1'b0, vecs[i].addr, 16'h0});
            ack_q.push_back('{vecs[i].pb, vecs[i].data});
            do_read(vecs[i].pb, vecs[i].addr);
        end

        resp_lat = 5;
        ioctl_download = 1'b1;
        @(negedge clk);
        acc_q.push_back('{1'b1, 24'h400008, 16'hBEEF});
        dl_write(27'h10, 16'hBEEF, 8'h01);
        chk("dl_wait_set", 64'(ioctl_wait), 64'(1));
        @(negedge clk);
        dl_write(27'h44, 16'hDEAD, 8'h00);
        wait_mem_ack("dl_mem_ack");
        chk("dl_wait_at_ack", 64'(ioctl_wait), 64'(1));
        @(negedge clk);
        chk("dl_wait_clr", 64'(ioctl_wait), 64'(0));
        repeat (3) @(negedge clk);

        resp_lat = 1;
        acc_q.push_back('{1'b1, 24'hFFFFFF, 16'h0F0F});
        dl_write(27'h3FFFFFE, 16'h0F0F, 8'hFF);
        wait_mem_ack("dl2_mem_ack");
        @(negedge clk);
        chk("dl2_wait_clr", 64'(ioctl_wait), 64'(0));
        repeat (2) @(negedge clk);

        resp_lat = 2;
        acc_q.push_back('{1'b1, 24'h800080, 16'h1357});
        acc_q.push_back('{1'b0, 24'h0055AA, 16'h0});
        ack_q.push_back('{1'b0, rd_model(24'h0055AA)});
        a_addr = 24'h0055AA;
        a_req = 1'b1;
        repeat (4) @(negedge clk);
        dl_write(27'h100, 16'h1357, 8'h02);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (a_ack) seen++;
        end
        chk("prio_hold_ack", 64'(seen), 64'(0));
        ioctl_download = 1'b0;
        wait_ack(1'b0);
        a_req = 1'b0;
        @(negedge clk);

        resp_en = 1'b0;
        chk("to_err_pre", 64'(timeout_err), 64'(0));
        acc_q.push_back('{1'b0, 24'h000ABC, 16'h0});
        ack_q.push_back('{1'b0, 16'hFFFF});
        do_read(1'b0, 24'h000ABC);
        chk("to_req_len", 64'(last_len), 64'(TO));
        chk("to_err_set", 64'(timeout_err), 64'(1));
        resp_en = 1'b1;
        resp_lat = 1;
        acc_q.push_back('{1'b0, 24'h000777, 16'h0});
        ack_q.push_back('{1'b1, rd_model(24'h000777)});
        do_read(1'b1, 24'h000777);
        chk("to_err_sticky", 64'(timeout_err), 64'(1));

        resp_lat = 6;
        acc_q.push_back('{1'b0, 24'h002222, 16'h0});
        ack_q.push_back('{1'b1, rd_model(24'h002222)});
        b_addr = 24'h002222;
        b_req = 1'b1;
        t = 0;
        while (mif.mem_req !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("rst_grant", 64'(mif.mem_req), 64'(1));
        @(negedge clk);
        ioctl_download = 1'b1;
        dl_write(27'h20, 16'h4444, 8'h00);
        chk("rst_pre_wait", 64'(ioctl_wait), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mem_req", 64'(mif.mem_req), 64'(0));
        chk("rst_wait", 64'(ioctl_wait), 64'(0));
        chk("rst_to_err", 64'(timeout_err), 64'(0));
        ack_q.delete();
        rst = 1'b0;
        b_req = 1'b0;
        ioctl_download = 1'b0;
        @(negedge clk);
        acc_q.push_back('{1'b0, 24'h002222, 16'h0});
        ack_q.push_back('{1'b1, rd_model(24'h002222)});
        do_read(1'b1, 24'h002222);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        resp_lat = 3;
        acc_q.push_back('{1'b0, 24'h000100, 16'h0});
        acc_q.push_back('{1'b0, 24'h000200, 16'h0});
        acc_q.push_back('{1'b0, 24'h000101, 16'h0});
        acc_q.push_back('{1'b0, 24'h000201, 16'h0});
        ack_q.push_back('{1'b0, rd_model(24'h000100)});
        ack_q.push_back('{1'b1, rd_model(24'h000200)});
        ack_q.push_back('{1'b0, rd_model(24'h000101)});
        ack_q.push_back('{1'b1, rd_model(24'h000201)});
        fork
            begin
                do_read(1'b0, 24'h000100);
                do_read(1'b0, 24'h000101);
            end
            begin
                do_read(1'b1, 24'h000200);
                do_read(1'b1, 24'h000201);
            end
        join

        repeat (5) @(negedge clk);
        chk("acc_q_empty", 64'(acc_q.size()), 64'(0));
        chk("ack_q_empty", 64'(ack_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
